// File: rtl/register_write_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared
// register. Each grant runs IDLE -> WRITE (one-cycle strobe and ack) ->
// RELEASE (wait for the winner to drop its request) -> IDLE.
//
// Handshake: req[i] is a 4-phase request. The requester holds req[i] high
// until it sees ack[i] (exactly one cycle wide, coincident with wr_en), then
// drops it. The arbiter returns to IDLE only once req[winner] is sampled low,
// so a request that stays high after its ack blocks further grants.
module register_write_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int DATA_W = 8,
  localparam int IDX_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic                   wr_en,
  output logic [DATA_W-1:0]      wr_data,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic [7:0]             write_count,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [7:0]          count_q, count_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      rr_sum;
  logic [IDX_W-1:0]    rr_cand;

  // Round-robin search: scan from ptr upward with wrap, first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NREQ)) rr_sum = rr_sum - (IDX_W+1)'(NREQ);
      rr_cand = rr_sum[IDX_W-1:0];
      if (!win_found && req[rr_cand]) begin
        win_found = 1'b1;
        win_idx   = rr_cand;
      end
    end
  end

  // Next-state and registered-output decode; strobe and ack default low.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = WRITE;
          wr_en_d          = 1'b1;
          ack_d[win_idx]   = 1'b1;
          wr_data_d        = req_data[win_idx*DATA_W +: DATA_W];
          owner_d          = win_idx;
          ptr_d            = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      WRITE: begin
        // The write completes on this edge; count it and wait for release.
        state_d = RELEASE;
        count_d = count_q + 8'd1;
      end
      RELEASE: begin
        if (!req[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
    end
  end

  assign ack         = ack_q;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign owner       = owner_q;
  assign write_count = count_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter (NREQ=4, DATA_W=8). A single process
// drives requests, mimics 4-phase requesters and checks every write strobe
// against a scoreboard queue of {owner, data} entries.
module tb_register_write_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic [1:0]             owner;
  logic                   busy;
  logic [7:0]             write_count;
  logic [1:0]             dbg_state;

  register_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .wr_en(wr_en), .wr_data(wr_data), .owner(owner),
    .busy(busy), .write_count(write_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and requester model state
  logic [9:0]      exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              n_wr   = 0;
  int              last_wr = -1;
  logic            chk_spacing;
  logic            push_on_rearm;
  logic [NREQ-1:0] auto_drop;
  logic [NREQ-1:0] pend;
  int              rearm[NREQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare a write strobe against the scoreboard head.
  task automatic mon_step();
    logic [9:0] e;
    if (rst_n && wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("sb_has_entry", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
        check("owner",   32'(owner),   32'(e[9:8]));
        check("ack",     32'(ack),     32'(4'b0001 << e[9:8]));
      end
      if (chk_spacing && last_wr >= 0) check("spacing", 32'(cyc - last_wr), 32'd3);
      last_wr = cyc;
    end else if (rst_n) begin
      check("ack_idle", 32'(ack), 32'd0);
    end
  endtask

  // 4-phase requester model: drop on ack, optionally re-raise once idle.
  task automatic drv_step();
    logic [7:0] d;
    for (int i = 0; i < NREQ; i++) begin
      if (auto_drop[i] && ack[i]) begin
        req[i]  = 1'b0;
        pend[i] = 1'b1;
      end else if (pend[i] && !busy) begin
        pend[i] = 1'b0;
        if (rearm[i] > 0) begin
          rearm[i]--;
          if (push_on_rearm) begin
            d = 8'($urandom_range(0, 255));
            req_data[i*DATA_W +: DATA_W] = d;
            exp_q.push_back({2'(i), d});
          end
          req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    drv_step();
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (exp_q.size() == 0) && !busy && (req == '0) && (pend == '0);
    for (int i = 0; i < NREQ; i++) if (rearm[i] != 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      tick();
      if (all_quiet()) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ack(input int idx, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      tick();
      if (ack[idx]) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 32'(ack), 32'(4'b0001 << idx));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    auto_drop = '0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) rearm[i] = 0;
    push_on_rearm = 1'b0;
    chk_spacing = 1'b0;
    last_wr = -1;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    auto_drop = '0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) rearm[i] = 0;
    push_on_rearm = 1'b0;
    chk_spacing = 1'b0;

    // reset state, before any clock edge
    #2;
    check("rst_wr_en",   32'(wr_en), 32'd0);
    check("rst_ack",     32'(ack), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_owner",   32'(owner), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_count",   32'(write_count), 32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);

    // single requester
    apply_reset();
    auto_drop[2] = 1'b1;
    req_data[2*DATA_W +: DATA_W] = 8'hAA;
    exp_q.push_back({2'd2, 8'hAA});
    req[2] = 1'b1;
    wait_idle(20);
    check("single_count", 32'(write_count), 32'd1);
    check("single_owner", 32'(owner), 32'd2);
    check("single_hold",  32'(wr_data), 32'hAA);

    // all four requesting at once: served 0,1,2,3
    apply_reset();
    auto_drop = 4'b1111;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd2, 8'h32});
    exp_q.push_back({2'd3, 8'h43});
    req = 4'b1111;
    wait_idle(40);
    check("all4_count", 32'(write_count), 32'd4);

    // fairness: 0 and 3 re-raise after each ack -> 0,3,0,3
    apply_reset();
    auto_drop = 4'b1001;
    rearm[0] = 1;
    rearm[3] = 1;
    req_data = {8'hB3, 8'h00, 8'h00, 8'hA0};
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd3, 8'hB3});
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd3, 8'hB3});
    req = 4'b1001;
    wait_idle(40);
    check("fair_count", 32'(write_count), 32'd4);

    // late release: req[1] held 5 cycles past its ack blocks req[0]
    apply_reset();
    auto_drop = 4'b0001;
    req_data = {8'h00, 8'h00, 8'h55, 8'h66};
    exp_q.push_back({2'd1, 8'h55});
    req[1] = 1'b1;
    wait_ack(1, 10);
    req[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("late_busy",  32'(busy), 32'd1);
      check("late_wr_en", 32'(wr_en), 32'd0);
    end
    // the data change after the grant must not reach wr_data
    req_data[1*DATA_W +: DATA_W] = 8'hEE;
    check("late_hold", 32'(wr_data), 32'h55);
    exp_q.push_back({2'd0, 8'h66});
    req[1] = 1'b0;
    wait_idle(20);
    check("late_count", 32'(write_count), 32'd2);

    // reset during WRITE cancels the strobe and the count
    apply_reset();
    auto_drop = 4'b1001;
    req_data = {8'h77, 8'h00, 8'h00, 8'h99};
    req[3] = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 10 && !hit; n++) begin
        @(posedge clk);
        #1;
        if (wr_en) hit = 1'b1;
      end
      check("rstw_reached_write", 32'(hit), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("rstw_wr_en", 32'(wr_en), 32'd0);
    check("rstw_ack",   32'(ack), 32'd0);
    check("rstw_busy",  32'(busy), 32'd0);
    check("rstw_count", 32'(write_count), 32'd0);
    tick();
    req[0] = 1'b1;
    exp_q.push_back({2'd0, 8'h99});
    exp_q.push_back({2'd3, 8'h77});
    rst_n = 1'b1;
    wait_idle(30);
    check("rstw_after_count", 32'(write_count), 32'd2);

    // wrap: 256 back-to-back writes from one requester, random data
    apply_reset();
    auto_drop = 4'b0010;
    push_on_rearm = 1'b1;
    chk_spacing = 1'b1;
    rearm[1] = 255;
    n_wr = 0;
    req_data[1*DATA_W +: DATA_W] = 8'h5A;
    exp_q.push_back({2'd1, 8'h5A});
    req[1] = 1'b1;
    wait_idle(1000);
    check("wrap_writes", 32'(n_wr), 32'd256);
    check("wrap_count",  32'(write_count), 32'd0);
    chk_spacing = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_write_arbiter.md
REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; the block SHALL support any value from 2 to 8.
REQ-002 Parameter DATA_W, default 8: width of the shared register data path.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port req, input, NREQ: request i asserted high by requester i until it sees ack[i], then dropped (4-phase).
REQ-006 Port req_data, input, NREQ*DATA_W: write data of requester i at bits [i*DATA_W +: DATA_W].
REQ-007 Port ack, output, NREQ: one-hot, one-cycle acknowledge to the granted requester.
REQ-008 Port wr_en, output, 1: write strobe to the shared register's write_enable.
REQ-009 Port wr_data, output, DATA_W: data to the shared register's data_in.
REQ-010 Port owner, output, clog2(NREQ): index of the most recently granted requester.
REQ-011 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-012 Port write_count, output, 8: total completed writes, modulo 256.

Function
REQ-013 All outputs SHALL be registered, except busy, which SHALL be decoded from the state register.
REQ-014 The FSM SHALL have three states: IDLE, WRITE and RELEASE.
REQ-015 IDLE, any req bit high at an edge: winner chosen, winner index and req_data slice latched, next state WRITE.
REQ-016 IDLE, no req: stay in IDLE, with wr_en=0 and ack=0.
REQ-017 Round-robin: search starts at ptr and wraps; first set req bit wins; ptr = (winner+1) mod NREQ, updated at the grant edge.
REQ-018 WRITE: wr_en=1, ack[winner]=1 and wr_data=latched data for exactly one cycle; next state RELEASE unconditionally.
REQ-019 Latency: req sampled at edge N in IDLE -> wr_en and ack high from edge N to edge N+1; the shared register captures at edge N+1.
REQ-020 RELEASE: stay until req[winner] is sampled low, then go to IDLE; other requests are ignored while in RELEASE.
REQ-021 wr_data SHALL hold the last written value outside WRITE; owner SHALL update at the grant edge.
REQ-022 write_count SHALL increment by 1 on the edge that leaves WRITE; it SHALL wrap from 255 to 0.
REQ-023 Maximum throughput SHALL be one write per 3 cycles (IDLE, WRITE, RELEASE with req already low).
REQ-024 A req dropped before being sampled in IDLE SHALL get no grant and no ack; no obligation is retained.
REQ-025 A req dropped during WRITE SHALL NOT abort the write; RELEASE then exits on its next edge.
REQ-026 A change of req_data after the grant edge SHALL NOT affect wr_data.
REQ-027 Simultaneous requests SHALL be served one per grant in round-robin order; starvation is impossible.
REQ-028 A non-one-hot or X-free ack violation SHALL never occur; at most one ack bit is high in any cycle.

Reset
REQ-029 rst_n low SHALL immediately, with no clock, force: state=IDLE, wr_en=0, ack=0, wr_data=0, owner=0, ptr=0, write_count=0, busy=0.
REQ-030 Reset asserted during WRITE SHALL cancel the strobe in the same cycle; write_count SHALL NOT increment.
REQ-031 After rst_n rises, the first arbitration SHALL be possible at the first rising edge with rst_n high.

Verification
REQ-032 Single requester: req[2]=1 with data 8'hAA -> one cycle of wr_en=1, wr_data=8'hAA, ack=4'b0100; owner=2; write_count=1.
REQ-033 All four requesting (data 8'h10, 8'h21, 8'h32, 8'h43), each dropping req after its ack -> writes 8'h10, 8'h21, 8'h32, 8'h43 in that order, each in a separate grant.
REQ-034 Fairness: req[0] and req[3] held continuously, re-raised immediately after each ack -> grants alternate 0,3,0,3; neither requester is granted twice in a row.
REQ-035 Late release: ack[1] given, req[1] held high for 5 more cycles -> busy stays 1; no wr_en; a concurrent req[0] is granted only after req[1] falls.
REQ-036 Reset mid-write: rst_n pulled low in the WRITE cycle -> wr_en and ack drop at once; write_count=0; busy=0; next grant goes to requester 0 if it is requesting.
REQ-037 Wrap: 256 back-to-back single-requester writes -> write_count returns to 0; every write shows the 3-cycle spacing.
